// File: rtl/instruction_decoder_pkg.sv
// Shared constants for the decode stage: opcodes, ALU control codes and XLEN.
package instruction_decoder_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instruction_decoder_reg_file.sv
// 32x64 integer register file, x0 hard-wired to zero, two combinational read ports.
// Optional same-cycle write-back forwarding enabled by defining WB_BYPASS_EN.
module reg_file
  import instruction_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] val_a,
  output logic [XLEN-1:0] val_b
);

  logic [XLEN-1:0] regs [1:31];
  logic            wr_ok;

  assign wr_ok = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    val_a = '0;
    val_b = '0;
    if (rs1 != 5'd0) val_a = regs[rs1];
    if (rs2 != 5'd0) val_b = regs[rs2];
`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle so decode sees it immediately.
    if (wr_ok && (wb_addr == rs1)) val_a = wb_data;
    if (wr_ok && (wb_addr == rs2)) val_b = wb_data;
`endif
  end

endmodule

// File: rtl/instruction_decoder.sv
// Decode stage: combinational control/ALU-code generation plus the integer register file.
// Define WB_BYPASS_EN to forward write-back data to ValA/ValB in the same cycle.
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ALU_src,
  output logic            Mem_to_Reg,
  output logic            Reg_Write,
  output logic            Mem_Read,
  output logic            Mem_Write,
  output logic            Branch_en,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] ValA,
  output logic [XLEN-1:0] ValB
);

  logic writes_rd;

  always_comb begin
    ALU_src    = 1'b0;
    Mem_to_Reg = 1'b0;
    writes_rd  = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Branch_en  = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        writes_rd = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_ADD;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_ctrl = ALU_SUB;
        end
      end
      OP_LOAD: begin
        ALU_src    = 1'b1;
        Mem_to_Reg = 1'b1;
        writes_rd  = 1'b1;
        Mem_Read   = 1'b1;
      end
      OP_STORE: begin
        ALU_src   = 1'b1;
        Mem_Write = 1'b1;
      end
      OP_BRANCH: begin
        Branch_en = 1'b1;
        alu_ctrl  = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Writing x0 is architecturally a no-op, so suppress the request at decode.
  assign Reg_Write = writes_rd && (rd != 5'd0);

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs1     (rs1),
    .rs2     (rs2),
    .val_a   (ValA),
    .val_b   (ValB)
  );

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed vector table, corner sequences, random vs model.
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        ALU_src, Mem_to_Reg, Reg_Write, Mem_Read, Mem_Write, Branch_en;
  logic [3:0]  alu_ctrl;
  logic [63:0] ValA, ValB;

  int errors = 0;
  int checks = 0;

  logic [63:0] mdl [32];

  instruction_decoder dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7(funct7), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ALU_src(ALU_src), .Mem_to_Reg(Mem_to_Reg),
    .Reg_Write(Reg_Write), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Branch_en(Branch_en), .alu_ctrl(alu_ctrl), .ValA(ValA), .ValB(ValB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register state: cleared by reset, updated on accepted writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 64'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      mdl[wb_addr] <= wb_data;
    end
  end

  function automatic logic [63:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return mdl[idx];
  endfunction

  // Returns {ALU_src, Mem_to_Reg, Reg_Write, Mem_Read, Mem_Write, Branch_en, alu_ctrl[3:0]}.
  function automatic logic [9:0] ref_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] d);
    logic [5:0] fl;
    logic [3:0] alu;
    fl  = 6'b000000;
    alu = 4'b0010;
    if (op == 7'b0110011) begin
      fl = 6'b001000;
      if (f7 == 7'h00 && f3 == 3'b111)      alu = 4'b0000;
      else if (f7 == 7'h00 && f3 == 3'b110) alu = 4'b0001;
      else if (f7 == 7'h20 && f3 == 3'b000) alu = 4'b0110;
    end else if (op == 7'b0000011) fl = 6'b111100;
    else if (op == 7'b0100011) fl = 6'b100010;
    else if (op == 7'b1100011) begin
      fl  = 6'b000001;
      alu = 4'b0110;
    end
    if (d == 5'd0) fl[3] = 1'b0;
    return {fl, alu};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {ALU_src, Mem_to_Reg, Reg_Write, Mem_Read, Mem_Write, Branch_en};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    opcode = op; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] a, b, d;
    logic [5:0] exp_flags;
    logic [3:0] exp_alu;
    logic [63:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [9:0] rc;
    rst_n = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    set_instr(7'd0, 3'd0, 7'd0, 5'd7, 5'd31, 5'd0);

    vecs[0]  = '{"add",      7'b0110011, 3'b000, 7'h00, 5'd1,  5'd2,  5'd3, 6'b001000, 4'b0010, 64'h11, 64'h22};
    vecs[1]  = '{"sub",      7'b0110011, 3'b000, 7'h20, 5'd4,  5'd5,  5'd6, 6'b001000, 4'b0110, 64'h0,  64'h0};
    vecs[2]  = '{"and",      7'b0110011, 3'b111, 7'h00, 5'd1,  5'd2,  5'd7, 6'b001000, 4'b0000, 64'h11, 64'h22};
    vecs[3]  = '{"or",       7'b0110011, 3'b110, 7'h00, 5'd2,  5'd1,  5'd7, 6'b001000, 4'b0001, 64'h22, 64'h11};
    vecs[4]  = '{"xor_dflt", 7'b0110011, 3'b100, 7'h00, 5'd1,  5'd1,  5'd9, 6'b001000, 4'b0010, 64'h11, 64'h11};
    vecs[5]  = '{"alt_f3_7", 7'b0110011, 3'b111, 7'h20, 5'd0,  5'd2,  5'd9, 6'b001000, 4'b0010, 64'h0,  64'h22};
    vecs[6]  = '{"ld",       7'b0000011, 3'b011, 7'h00, 5'd7,  5'd0,  5'd8, 6'b111100, 4'b0010, 64'h0,  64'h0};
    vecs[7]  = '{"sd",       7'b0100011, 3'b011, 7'h00, 5'd9,  5'd10, 5'd0, 6'b100010, 4'b0010, 64'h0,  64'h0};
    vecs[8]  = '{"beq",      7'b1100011, 3'b000, 7'h00, 5'd11, 5'd12, 5'd4, 6'b000001, 4'b0110, 64'h0,  64'h0};
    vecs[9]  = '{"illegal",  7'b1111111, 3'b111, 7'h7f, 5'd1,  5'd2,  5'd3, 6'b000000, 4'b0010, 64'h11, 64'h22};
    vecs[10] = '{"r_rd0",    7'b0110011, 3'b000, 7'h00, 5'd1,  5'd2,  5'd0, 6'b000000, 4'b0010, 64'h11, 64'h22};
    vecs[11] = '{"ld_rd0",   7'b0000011, 3'b000, 7'h00, 5'd2,  5'd1,  5'd0, 6'b110100, 4'b0010, 64'h22, 64'h11};
    vecs[12] = '{"sd_rdnz",  7'b0100011, 3'b000, 7'h55, 5'd1,  5'd3,  5'd8, 6'b100010, 4'b0010, 64'h11, 64'h0};

    // Registers read zero while reset is held, even with a write pending.
    #2;
    check("rst_valA", ValA, 64'd0);
    check("rst_valB", ValB, 64'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'hFFFF;
    @(posedge clk); #1;
    check("rst_write_ignored", ValA, 64'd0);
    @(negedge clk);
    wb_en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_valA", ValA, 64'd0);

    write_reg(5'd1, 64'h11);
    write_reg(5'd2, 64'h22);

    foreach (vecs[i]) begin
      @(negedge clk);
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].d);
      #1;
      check({vecs[i].name, "_flags"}, {58'd0, dut_flags()}, {58'd0, vecs[i].exp_flags});
      check({vecs[i].name, "_alu"},   {60'd0, alu_ctrl},    {60'd0, vecs[i].exp_alu});
      check({vecs[i].name, "_valA"},  ValA, vecs[i].exp_a);
      check({vecs[i].name, "_valB"},  ValB, vecs[i].exp_b);
    end

    // x0 ignores writes.
    write_reg(5'd0, 64'hFF);
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("x0_valA", ValA, 64'd0);
    check("x0_valB", ValB, 64'd0);

    // Same-cycle read of a register being written.
    @(negedge clk);
    rs1 = 5'd3; rs2 = 5'd3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h55;
    #1;
`ifdef WB_BYPASS_EN
    check("same_cycle_valA", ValA, 64'h55);
    check("same_cycle_valB", ValB, 64'h55);
`else
    check("same_cycle_valA", ValA, 64'h0);
    check("same_cycle_valB", ValB, 64'h0);
`endif
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    check("after_edge_valA", ValA, 64'h55);

    // Asynchronous reset mid-run wipes state and discards a concurrent write.
    write_reg(5'd5, 64'hABCD);
    rs1 = 5'd5; rs2 = 5'd1;
    #1;
    check("pre_rst_x5", ValA, 64'hABCD);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_x5", ValA, 64'd0);
    check("async_rst_x1", ValB, 64'd0);
    @(posedge clk); #1;
    check("rst_discard_write", ValA, 64'd0);
    @(negedge clk);
    wb_en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("after_rst_x5", ValA, 64'd0);

    // Random instructions and write-back traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic [6:0] f7;
      @(negedge clk);
      case ($urandom_range(0, 4))
        0: op = 7'b0110011;
        1: op = 7'b0000011;
        2: op = 7'b0100011;
        3: op = 7'b1100011;
        default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      set_instr(op, 3'($urandom), f7, 5'($urandom), 5'($urandom), 5'($urandom));
      wb_en   = ($urandom_range(0, 2) != 0);
      wb_addr = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
      wb_data = {$urandom, $urandom};
      #1;
      rc = ref_ctrl(opcode, funct3, funct7, rd);
      check("rand_flags", {58'd0, dut_flags()}, {58'd0, rc[9:4]});
      check("rand_alu",   {60'd0, alu_ctrl},    {60'd0, rc[3:0]});
      check("rand_valA",  ValA, ref_read(rs1));
      check("rand_valB",  ValB, ref_read(rs2));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
